hdmi_mem_arb: RTL

Two-port arbiter sharing the single PSRAM memory-interface (mi_*) command/data bus. Port 0 carries the HDMI scan-out DMA, which is real-time and has priority. Port 1 carries a secondary requester (CPU bridge / blitter, reads and writes). The block grants one burst at a time, holds ownership until the burst's last data beat, then re-arbitrates. A consecutive-grant limit guarantees port 1 forward progress.

---
 rtl/hdmi_mem_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hdmi_mem_arb.sv
// Two-port arbiter for the shared PSRAM memory-interface bus.
// Port 0 (HDMI scan-out) has priority; a consecutive-grant limit keeps port 1 moving.
module hdmi_mem_arb #(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [22:0] p0_addr,
  input  logic [6:0]  p0_len,
  input  logic        p0_rw,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [15:0] p0_wdata,
  output logic        p0_wack,
  output logic        p0_wlast,
  output logic [15:0] p0_rdata,
  output logic        p0_rstb,
  output logic        p0_rlast,

  input  logic [22:0] p1_addr,
  input  logic [6:0]  p1_len,
  input  logic        p1_rw,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [15:0] p1_wdata,
  output logic        p1_wack,
  output logic        p1_wlast,
  output logic [15:0] p1_rdata,
  output logic        p1_rstb,
  output logic        p1_rlast,

  output logic [22:0] mi_addr,
  output logic [6:0]  mi_len,
  output logic        mi_rw,
  output logic        mi_valid,
  input  logic        mi_ready,
  output logic [15:0] mi_wdata,
  input  logic        mi_wack,
  input  logic        mi_wlast,
  input  logic [15:0] mi_rdata,
  input  logic        mi_rstb,
  input  logic        mi_rlast
);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  localparam logic [3:0] MaxConsec = 4'(MAX_CONSEC);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rw_l_q, rw_l_d;
  logic [3:0] consec_q, consec_d;

  logic in_cmd, in_data, owner_valid, burst_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rw_l_q   <= 1'b0;
      consec_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rw_l_q   <= rw_l_d;
      consec_q <= consec_d;
    end
  end

  assign in_cmd      = (state_q == StCmd);
  assign in_data     = (state_q == StData);
  assign owner_valid = owner_q ? p1_valid : p0_valid;
  assign burst_done  = (rw_l_q & mi_rstb & mi_rlast) | (~rw_l_q & mi_wack & mi_wlast);

  // Command/data bus always carries the owner's fields; only mi_valid is gated by state.
  always_comb begin
    mi_addr  = owner_q ? p1_addr  : p0_addr;
    mi_len   = owner_q ? p1_len   : p0_len;
    mi_rw    = owner_q ? p1_rw    : p0_rw;
    mi_wdata = owner_q ? p1_wdata : p0_wdata;
    mi_valid = in_cmd & owner_valid;
  end

  always_comb begin
    p0_ready = in_cmd & ~owner_q & mi_ready;
    p1_ready = in_cmd &  owner_q & mi_ready;
    p0_rstb  = in_data & ~owner_q & mi_rstb;
    p1_rstb  = in_data &  owner_q & mi_rstb;
    p0_rlast = in_data & ~owner_q & mi_rlast;
    p1_rlast = in_data &  owner_q & mi_rlast;
    p0_wack  = in_data & ~owner_q & mi_wack;
    p1_wack  = in_data &  owner_q & mi_wack;
    p0_wlast = in_data & ~owner_q & mi_wlast;
    p1_wlast = in_data &  owner_q & mi_wlast;
    p0_rdata = mi_rdata;
    p1_rdata = mi_rdata;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rw_l_d   = rw_l_q;
    consec_d = consec_q;
    unique case (state_q)
      StIdle: begin
        if (p1_valid && (!p0_valid || consec_q == MaxConsec)) begin
          owner_d  = 1'b1;
          consec_d = 4'd0;
          state_d  = StCmd;
        end else if (p0_valid) begin
          owner_d = 1'b0;
          state_d = StCmd;
          // Only count port-0 wins that actually made port 1 wait.
          if (!p1_valid) begin
            consec_d = 4'd0;
          end else if (consec_q != MaxConsec) begin
            consec_d = consec_q + 4'd1;
          end
        end
      end
      StCmd: begin
        if (mi_valid && mi_ready) begin
          rw_l_d  = mi_rw;
          state_d = StData;
        end
      end
      StData: begin
        if (burst_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
